ascii_to_bcd: RTL

Receive-side command parser for the vending machine's serial console. It takes ASCII bytes from the UART receiver one at a time and assembles up to three decimal digits into a right-justified 12-bit BCD amount. The amount is released when a carriage return arrives. Output feeds the same `amount_bcd` domain that the display and ASCII message path consume, so an operator can type an amount over the serial link.

---
 rtl/ascii_to_bcd.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ascii_to_bcd.sv
// Serial console amount parser: collects up to NDIG ASCII decimal digits and
// releases them as a right-justified BCD amount when a carriage return arrives.
module ascii_to_bcd #(
    parameter int NDIG = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [4*NDIG-1:0] amount_bcd,
    output logic              amount_valid,
    output logic              cmd_error,
    output logic              busy
);

    localparam int AW = 4 * NDIG;
    localparam int CW = $clog2(NDIG + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIGITS  = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        C_DIGIT = 3'd0,
        C_CR    = 3'd1,
        C_LF    = 3'd2,
        C_SPACE = 3'd3,
        C_BS    = 3'd4,
        C_OTHER = 3'd5
    } cls_t;

    function automatic cls_t classify(input logic [7:0] b);
        cls_t c;
        case (b)
            8'h0D:   c = C_CR;
            8'h0A:   c = C_LF;
            8'h20:   c = C_SPACE;
            8'h08:   c = C_BS;
            default: c = ((b >= 8'h30) && (b <= 8'h39)) ? C_DIGIT : C_OTHER;
        endcase
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   amount_q, amount_d;
    logic            amount_valid_q, amount_valid_d;
    logic            cmd_error_q, cmd_error_d;
    logic            busy_q, busy_d;
    cls_t            cls_s;
    logic            full_s;

    assign cls_s  = classify(rx_data);
    assign full_s = (cnt_q == CW'(NDIG));

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            acc_q          <= '0;
            cnt_q          <= '0;
            amount_q       <= '0;
            amount_valid_q <= 1'b0;
            cmd_error_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            amount_q       <= amount_d;
            amount_valid_q <= amount_valid_d;
            cmd_error_q    <= cmd_error_d;
            busy_q         <= busy_d;
        end
    end

    // Next state, accumulator and digit count
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    case (cls_s)
                        C_DIGIT: begin
                            acc_d   = {{(AW-4){1'b0}}, rx_data[3:0]};
                            cnt_d   = CW'(1);
                            state_d = S_DIGITS;
                        end
                        C_OTHER: state_d = S_DISCARD;
                        default: state_d = S_IDLE;
                    endcase
                end
                S_DIGITS: begin
                    case (cls_s)
                        C_DIGIT: begin
                            if (full_s) begin
                                acc_d   = '0;
                                cnt_d   = '0;
                                state_d = S_DISCARD;
                            end else begin
                                acc_d = {acc_q[AW-5:0], rx_data[3:0]};
                                cnt_d = cnt_q + CW'(1);
                            end
                        end
                        C_CR, C_OTHER: begin
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = (cls_s == C_CR) ? S_IDLE : S_DISCARD;
                        end
                        C_BS: begin
                            acc_d   = acc_q >> 4;
                            cnt_d   = cnt_q - CW'(1);
                            state_d = (cnt_q == CW'(1)) ? S_IDLE : S_DIGITS;
                        end
                        default: state_d = S_DIGITS;
                    endcase
                end
                S_DISCARD: begin
                    if (cls_s == C_CR) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output pulses and amount update, captured on the edge that samples the byte
    always_comb begin
        amount_d       = amount_q;
        amount_valid_d = 1'b0;
        cmd_error_d    = 1'b0;
        busy_d         = (state_d != S_IDLE);
        if (rx_valid) begin
            case (state_q)
                S_IDLE:   cmd_error_d = (cls_s == C_OTHER);
                S_DIGITS: begin
                    case (cls_s)
                        C_DIGIT: cmd_error_d = full_s;
                        C_OTHER: cmd_error_d = 1'b1;
                        C_CR: begin
                            amount_d       = acc_q;
                            amount_valid_d = 1'b1;
                        end
                        default: cmd_error_d = 1'b0;
                    endcase
                end
                default: cmd_error_d = 1'b0;
            endcase
        end else begin
            amount_d = amount_q;
        end
    end

    assign amount_bcd   = amount_q;
    assign amount_valid = amount_valid_q;
    assign cmd_error    = cmd_error_q;
    assign busy         = busy_q;

endmodule
